// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the byte-stream instruction-memory loader.
package boot_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WE_W   = 4;
  localparam int unsigned LANE_W = 2;

  localparam logic [BYTE_W-1:0] DEFAULT_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream input and BRAM port-B write bus of the loader.
interface boot_loader_if;
  import boot_loader_pkg::*;

  logic [BYTE_W-1:0] rx_data_i;
  logic              rx_valid_i;
  logic              rx_ready_o;
  logic              enb_o;
  logic [WE_W-1:0]   web_o;
  logic [ADDR_W-1:0] addrb_o;
  logic [WORD_W-1:0] dinb_o;

  modport slave (
    input  rx_data_i, rx_valid_i,
    output rx_ready_o, enb_o, web_o, addrb_o, dinb_o
  );

  modport master (
    output rx_data_i, rx_valid_i,
    input  rx_ready_o, enb_o, web_o, addrb_o, dinb_o
  );
endinterface

// File: rtl/boot_loader_word_pack.sv
// Packs four consecutive bytes into a little-endian 32-bit word.
module boot_loader_word_pack
  import boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              full_c,
  output logic [WORD_W-1:0] word_c
);

  logic [LANE_W-1:0] lane;
  logic [WORD_W-1:0] shreg;

  // Bytes enter at the top and shift down, so the first byte ends in [7:0].
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane  <= '0;
      shreg <= '0;
    end else if (push) begin
      lane  <= lane + LANE_W'(1);
      shreg <= {byte_in, shreg[WORD_W-1:BYTE_W]};
    end
  end

  always_comb begin
    full_c = push && (lane == LANE_W'(3));
    word_c = {byte_in, shreg[WORD_W-1:BYTE_W]};
  end

endmodule

// File: rtl/boot_loader.sv
// Frame parser that writes an image into BRAM port B and holds the core in
// reset until the image checksum has been verified.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned       MAX_WORDS = 4096,
  parameter logic [BYTE_W-1:0] MAGIC     = DEFAULT_MAGIC
) (
  input  logic          clk,
  input  logic          rst,
  boot_loader_if.slave  bus,
  output logic          core_rst_o,
  output logic          done_o,
  output logic          err_o
);

  state_e             state;
  logic [BYTE_W-1:0]  len_lo;
  logic [LEN_W-1:0]   count;
  logic [BYTE_W-1:0]  sum;
  logic [ADDR_W-1:0]  addr_q;
  logic [WORD_W-1:0]  din_q;
  logic               enb_q;
  logic [WE_W-1:0]    web_q;

  logic               ready_c;
  logic               accept_c;
  logic               start_c;
  logic               push_c;
  logic [LEN_W-1:0]   frame_len_c;
  logic               pack_full_c;
  logic [WORD_W-1:0]  pack_word_c;

  // Handshake decode; a magic byte restarts from any resting state.
  always_comb begin
    ready_c     = (state != ST_WRITE);
    accept_c    = bus.rx_valid_i && ready_c;
    start_c     = accept_c && (bus.rx_data_i == MAGIC) &&
                  ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    push_c      = accept_c && (state == ST_DATA);
    frame_len_c = {bus.rx_data_i, len_lo};
  end

  boot_loader_word_pack u_word_pack (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_c),
    .push    (push_c),
    .byte_in (bus.rx_data_i),
    .full_c  (pack_full_c),
    .word_c  (pack_word_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      len_lo     <= '0;
      count      <= '0;
      sum        <= '0;
      addr_q     <= BASE_ADDR;
      din_q      <= '0;
      enb_q      <= 1'b0;
      web_q      <= '0;
      core_rst_o <= 1'b1;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      enb_q <= 1'b0;
      web_q <= '0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_c) begin
            state      <= ST_LEN0;
            err_o      <= 1'b0;
            done_o     <= 1'b0;
            core_rst_o <= 1'b1;
            addr_q     <= BASE_ADDR;
            sum        <= '0;
          end
        end
        ST_LEN0: begin
          if (accept_c) begin
            len_lo <= bus.rx_data_i;
            state  <= ST_LEN1;
          end
        end
        ST_LEN1: begin
          if (accept_c) begin
            count <= frame_len_c;
            if (frame_len_c == '0) begin
              state <= ST_CSUM;
            end else if (32'(frame_len_c) > MAX_WORDS) begin
              state      <= ST_ERR;
              err_o      <= 1'b1;
              core_rst_o <= 1'b1;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (accept_c) begin
            sum <= sum + bus.rx_data_i;
            if (pack_full_c) begin
              din_q <= pack_word_c;
              enb_q <= 1'b1;
              web_q <= '1;
              state <= ST_WRITE;
            end
          end
        end
        // Write strobe is visible this cycle; advance address for the next word.
        ST_WRITE: begin
          addr_q <= addr_q + ADDR_W'(4);
          count  <= count - LEN_W'(1);
          state  <= (count == LEN_W'(1)) ? ST_CSUM : ST_DATA;
        end
        ST_CSUM: begin
          if (accept_c) begin
            if (bus.rx_data_i == sum) begin
              state      <= ST_DONE;
              done_o     <= 1'b1;
              core_rst_o <= 1'b0;
            end else begin
              state      <= ST_ERR;
              err_o      <= 1'b1;
              core_rst_o <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rx_ready_o = ready_c;
  assign bus.enb_o      = enb_q;
  assign bus.web_o      = web_q;
  assign bus.addrb_o    = addr_q;
  assign bus.dinb_o     = din_q;

endmodule

// File: tb/tb_boot_loader.sv
// Randomized frame-level bench for boot_loader with a frame-level expectation model.
module tb_boot_loader;
  import boot_loader_pkg::*;

  typedef logic [7:0] bq_t[$];

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 4096;

  logic clk = 1'b0;
  logic rst;
  logic core_rst, done, err;

  always #5 clk = ~clk;

  boot_loader_if bl();

  boot_loader dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bl),
    .core_rst_o (core_rst),
    .done_o     (done),
    .err_o      (err)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] got_addr[$], got_data[$], exp_addr[$], exp_data[$];
  logic [3:0]  got_web[$];
  logic        got_rdy[$];
  int          acc_cnt = 0;
  int          sent_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Observe the BRAM port and the byte handshake mid-cycle.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (bl.enb_o) begin
        got_addr.push_back(bl.addrb_o);
        got_data.push_back(bl.dinb_o);
        got_web.push_back(bl.web_o);
        got_rdy.push_back(bl.rx_ready_o);
      end
      if (bl.rx_valid_i && bl.rx_ready_o) acc_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      bl.rx_valid_i = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bl.rx_valid_i = 1'b1;
    bl.rx_data_i  = b;
    n = 0;
    while (!bl.rx_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'(n), 32'd0);
    @(negedge clk);
    bl.rx_valid_i = 1'b0;
    sent_cnt++;
  endtask

  // Sends one frame and records the writes and status it should produce.
  task automatic run_frame(input logic [15:0] len, input bq_t payload,
                           input logic [7:0] csum_delta, input bit gaps,
                           output bit ok);
    logic [7:0] s;
    s = 8'h00;
    send_byte(8'hA5, gaps);
    send_byte(len[7:0], gaps);
    send_byte(len[15:8], gaps);
    if (int'(len) > MAXW) begin
      ok = 1'b0;
      return;
    end
    for (int i = 0; i < payload.size(); i++) begin
      s = s + payload[i];
      send_byte(payload[i], gaps);
      if (i % 4 == 3) begin
        exp_addr.push_back(BASE + 32'(4 * (i / 4)));
        exp_data.push_back({payload[i], payload[i-1], payload[i-2], payload[i-3]});
      end
    end
    send_byte(s + csum_delta, gaps);
    ok = (csum_delta == 8'h00);
  endtask

  task automatic check_status(input string tag, input logic c_e, input logic d_e, input logic e_e);
    check({tag, "_core_rst"}, 32'(core_rst), 32'(c_e));
    check({tag, "_done"}, 32'(done), 32'(d_e));
    check({tag, "_err"}, 32'(err), 32'(e_e));
  endtask

  task automatic compare_writes(input string tag);
    repeat (3) @(negedge clk);
    check({tag, "_nwrites"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check({tag, "_addr"}, got_addr[i], exp_addr[i]);
      check({tag, "_data"}, got_data[i], exp_data[i]);
      check({tag, "_web"}, 32'(got_web[i]), 32'hF);
      check({tag, "_rdy_in_write"}, 32'(got_rdy[i]), 32'd0);
    end
    check({tag, "_consumed"}, 32'(acc_cnt), 32'(sent_cnt));
    got_addr.delete(); got_data.delete(); got_web.delete(); got_rdy.delete();
    exp_addr.delete(); exp_data.delete();
    acc_cnt = 0;
    sent_cnt = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bq_t spec_pl, empty_pl, pl;
    bit  ok;
    logic [7:0] g;

    spec_pl  = '{8'h13, 8'h05, 8'h20, 8'h00, 8'h93, 8'h05, 8'h15, 8'h00};
    empty_pl = {};
    rst = 1'b1;
    bl.rx_valid_i = 1'b0;
    bl.rx_data_i  = 8'h00;
    repeat (3) @(negedge clk);

    check_status("reset", 1'b1, 1'b0, 1'b0);
    check("reset_enb", 32'(bl.enb_o), 32'd0);
    check("reset_web", 32'(bl.web_o), 32'd0);
    check("reset_addr", bl.addrb_o, BASE);
    check("reset_din", bl.dinb_o, 32'd0);
    check("reset_ready", 32'(bl.rx_ready_o), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Reference frame, continuous source.
    run_frame(16'd2, spec_pl, 8'h00, 1'b0, ok);
    check_status("spec", 1'b0, 1'b1, 1'b0);
    compare_writes("spec");

    // Wrong checksum, then recovery with a good frame.
    run_frame(16'd2, spec_pl, 8'hFF, 1'b0, ok);
    check_status("badsum", 1'b1, 1'b0, 1'b1);
    compare_writes("badsum");
    run_frame(16'd2, spec_pl, 8'h00, 1'b1, ok);
    check_status("recover", 1'b0, 1'b1, 1'b0);
    compare_writes("recover");

    // Empty image.
    run_frame(16'd0, empty_pl, 8'h00, 1'b0, ok);
    check_status("len0", 1'b0, 1'b1, 1'b0);
    compare_writes("len0");

    // Oversized length, then a stray data byte that must be dropped.
    run_frame(16'd4097, empty_pl, 8'h00, 1'b0, ok);
    check_status("toolong", 1'b1, 1'b0, 1'b1);
    send_byte(8'h13, 1'b0);
    check_status("toolong_drop", 1'b1, 1'b0, 1'b1);
    check("toolong_addr", bl.addrb_o, BASE);
    compare_writes("toolong");

    // Random frames with leading garbage, gapped or continuous.
    for (int f = 0; f < 8; f++) begin
      logic [7:0] delta;
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g, 1'b1);
      end
      pl = {};
      begin
        int len;
        len = $urandom_range(1, 6);
        for (int i = 0; i < 4 * len; i++) pl.push_back(8'($urandom_range(0, 255)));
        delta = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        run_frame(16'(len), pl, delta, bit'(f % 2), ok);
      end
      check_status($sformatf("rand%0d", f), !ok, ok, !ok);
      compare_writes($sformatf("rand%0d", f));
    end

    // Reset after six data bytes abandons the frame.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(spec_pl[i], 1'b1);
    exp_addr.push_back(BASE);
    exp_data.push_back(32'h0020_0513);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_status("midrst", 1'b1, 1'b0, 1'b0);
    check("midrst_addr", bl.addrb_o, BASE);
    check("midrst_enb", 32'(bl.enb_o), 32'd0);
    compare_writes("midrst");
    run_frame(16'd2, spec_pl, 8'h00, 1'b1, ok);
    check_status("after_rst", 1'b0, 1'b1, 1'b0);
    compare_writes("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
